// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: steps each instruction through IF/ID/EXE/MEM/WB,
// drives datapath enables and mux selects, and counts retired instructions.
module mc_control_unit #(
  parameter int OP_WIDTH  = 6,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [OP_WIDTH-1:0]  opcode,
  input  logic                 zero,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 mem_we,
  output logic                 alu_src_b,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_HALT  = OP_WIDTH'(6'b111111);

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  retire;
  logic                  we_en;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        op_d = opcode;
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (opcode == OP_RTYPE || opcode == OP_ADDI || opcode == OP_LW ||
                     opcode == OP_SW || opcode == OP_BEQ) begin
          state_d = S_EXE;
        end else begin
          // j and every undefined opcode finish here
          state_d = S_IF;
          retire  = 1'b1;
        end
      end
      S_EXE: begin
        if (op_q == OP_BEQ) begin
          state_d = S_IF;
          retire  = 1'b1;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else if (op_q == OP_RTYPE || op_q == OP_ADDI) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM: begin
        if (op_q == OP_SW) begin
          state_d = S_IF;
          retire  = 1'b1;
        end else if (op_q == OP_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        state_d = S_IF;
        retire  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    cnt_d = retire ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enables are gated by stall and reset; selects stay decoded from state.
  assign we_en = !stall && !reset;

  always_comb begin
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_we     = 1'b0;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we = we_en;
        pc_we = we_en;
      end
      S_ID: begin
        if (opcode == OP_J) begin
          pc_we  = we_en;
          pc_src = 2'b10;
        end
      end
      S_EXE: begin
        alu_src_b = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
        if (op_q == OP_BEQ) begin
          pc_src = 2'b01;
          pc_we  = we_en && zero;
        end
      end
      S_MEM: mem_we = we_en && (op_q == OP_SW);
      S_WB: begin
        rf_we      = we_en;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model driven by
// directed programs and randomized instruction streams with stalls and resets.
module tb_mc_control_unit;

  localparam int ST_IF = 0, ST_ID = 1, ST_EXE = 2, ST_MEM = 3, ST_WB = 4, ST_HALT = 5;
  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_HALT = 6, C_NOP = 7;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_HALT = 6'b111111, OP_UNK = 6'b010101;

  logic        clk = 1'b0;
  logic        reset, stall, zero;
  logic [5:0]  opcode;
  logic        pc_we, ir_we, rf_we, mem_we, alu_src_b, reg_dst, mem_to_reg, halted;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic        w_pc_we, w_ir_we, w_rf_we, w_mem_we, w_alu_src_b, w_reg_dst, w_mem_to_reg, w_halted;
  logic [1:0]  w_pc_src;
  logic [2:0]  w_state;
  logic [3:0]  w_instr_count;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .rf_we(rf_we), .mem_we(mem_we),
    .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .halted(halted), .instr_count(instr_count)
  );

  mc_control_unit #(.OP_WIDTH(6), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .opcode(opcode), .zero(zero),
    .pc_we(w_pc_we), .pc_src(w_pc_src), .ir_we(w_ir_we), .rf_we(w_rf_we), .mem_we(w_mem_we),
    .alu_src_b(w_alu_src_b), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .state(w_state), .halted(w_halted), .instr_count(w_instr_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_state;
  int          m_cls;
  int          m_rest[$];
  logic [31:0] m_cnt;
  logic [5:0]  cur_op;

  function automatic int classify(input logic [5:0] op);
    case (op)
      OP_R:    return C_R;
      OP_ADDI: return C_ADDI;
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_BEQ:  return C_BEQ;
      OP_J:    return C_J;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step the model one step along the remaining path of the current instruction.
  task automatic finish_step();
    if (m_rest.size() == 0) begin
      m_cnt++;
      m_state = ST_IF;
    end else begin
      m_state = m_rest.pop_front();
    end
  endtask

  // One clock cycle: drive at edge+1, check at edge+5, update model after the edge.
  task automatic tick(input logic st, input logic rs, input logic z);
    logic       en;
    logic [3:0] e_we;
    logic [4:0] e_sel;
    stall  = st;
    reset  = rs;
    zero   = z;
    opcode = (m_state == ST_ID && !rs) ? cur_op : 6'($urandom);
    if (rs) begin
      m_state = ST_IF;
      m_cnt   = '0;
      m_rest.delete();
    end
    en    = !st && !rs;
    e_we  = '0;
    e_sel = '0;
    case (m_state)
      ST_IF: e_we = {en, en, 1'b0, 1'b0};
      ST_ID: if (classify(opcode) == C_J) begin
        e_we[3]    = en;
        e_sel[4:3] = 2'b10;
      end
      ST_EXE: begin
        e_sel[2] = (m_cls == C_ADDI) || (m_cls == C_LW) || (m_cls == C_SW);
        if (m_cls == C_BEQ) begin
          e_sel[4:3] = 2'b01;
          e_we[3]    = en && z;
        end
      end
      ST_MEM: e_we[0] = en && (m_cls == C_SW);
      ST_WB: begin
        e_we[1]  = en;
        e_sel[1] = (m_cls == C_R);
        e_sel[0] = (m_cls == C_LW);
      end
      default: ;
    endcase
    #4;
    check_eq("state", 32'(state), 32'(m_state));
    check_eq("we", 32'({pc_we, ir_we, rf_we, mem_we}), 32'(e_we));
    check_eq("sel", 32'({pc_src, alu_src_b, reg_dst, mem_to_reg}), 32'(e_sel));
    check_eq("halted", 32'(halted), 32'(m_state == ST_HALT));
    check_eq("count", instr_count, m_cnt);
    check_eq("count_w4", 32'(w_instr_count), 32'(m_cnt[3:0]));
    check_eq("state_w4", 32'(w_state), 32'(m_state));
    @(posedge clk);
    #1;
    if (!rs && !st) begin
      case (m_state)
        ST_IF: m_state = ST_ID;
        ST_ID: begin
          m_cls = classify(opcode);
          m_rest.delete();
          case (m_cls)
            C_R, C_ADDI: begin m_rest.push_back(ST_EXE); m_rest.push_back(ST_WB); end
            C_LW: begin
              m_rest.push_back(ST_EXE); m_rest.push_back(ST_MEM); m_rest.push_back(ST_WB);
            end
            C_SW: begin m_rest.push_back(ST_EXE); m_rest.push_back(ST_MEM); end
            C_BEQ: m_rest.push_back(ST_EXE);
            default: ;
          endcase
          if (m_cls == C_HALT) begin
            m_state = ST_HALT;
            m_cnt++;
          end else begin
            finish_step();
          end
        end
        ST_HALT: ;
        default: finish_step();
      endcase
    end
  endtask

  // Run one instruction from IF until it retires, halts, or is reset.
  // zmode: 0/1 fixed zero flag, 2 random every cycle.
  task automatic do_instr(input logic [5:0] op, input int zmode, input int stall_pct,
                          input int mem_stall, input bit rst_wb, input int rst_pct);
    int  n;
    bit  left;
    bit  done;
    int  ms;
    n    = 0;
    left = 0;
    done = 0;
    ms   = mem_stall;
    cur_op = op;
    while (n < 60 && !done) begin
      logic st, rs, z;
      st = ($urandom_range(99) < stall_pct);
      if (ms > 0 && m_state == ST_MEM) begin
        st = 1'b1;
        ms--;
      end
      rs = (rst_wb && m_state == ST_WB) || ($urandom_range(999) < rst_pct);
      z  = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      tick(st, rs, z);
      n++;
      if (m_state != ST_IF) left = 1;
      if (rs || m_state == ST_HALT || (left && m_state == ST_IF)) done = 1;
    end
    check_eq("instr_done", 32'(done), 32'd1);
  endtask

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(15);
    case (r)
      0, 1:   return OP_R;
      2, 3:   return OP_ADDI;
      4, 5:   return OP_LW;
      6, 7:   return OP_SW;
      8, 9:   return OP_BEQ;
      10:     return OP_J;
      11:     return OP_HALT;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    stall   = 1'b0;
    zero    = 1'b0;
    opcode  = '0;
    m_state = ST_IF;
    m_cnt   = '0;
    m_cls   = C_NOP;
    cur_op  = '0;
    @(posedge clk);
    #1;
    tick(1'b0, 1'b1, 1'b0);

    do_instr(OP_R, 0, 0, 0, 0, 0);
    do_instr(OP_LW, 0, 0, 0, 0, 0);
    do_instr(OP_SW, 0, 0, 0, 0, 0);
    do_instr(OP_BEQ, 1, 0, 0, 0, 0);
    do_instr(OP_BEQ, 0, 0, 0, 0, 0);
    do_instr(OP_J, 0, 0, 0, 0, 0);
    do_instr(OP_UNK, 0, 0, 0, 0, 0);
    do_instr(OP_HALT, 0, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) tick(1'($urandom), 1'b0, 1'($urandom));
    tick(1'b0, 1'b1, 1'b0);

    do_instr(OP_SW, 0, 0, 3, 0, 0);
    do_instr(OP_ADDI, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) do_instr(OP_UNK, 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 250; i++) begin
      do_instr(rand_op(), 2, 20, 0, 0, 15);
      if (m_state == ST_HALT) begin
        for (int k = 0; k < 4; k++) tick(1'($urandom), 1'b0, 1'($urandom));
        tick(1'b0, 1'b1, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
